// File: rtl/display_scanner.sv
// display_scanner: time-multiplexed 4-digit display driver with blanking between
// digits and a shadow register so each frame shows one consistent value.
module display_scanner #(
  parameter int BLANK_CYC = 2,
  parameter int DIGIT_CYC = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] data_in,
  output logic [3:0]  char,
  output logic        an_blank,
  output logic [3:0]  an,
  output logic        pending,
  output logic        frame_done
);
  localparam int CW = $clog2((BLANK_CYC > DIGIT_CYC ? BLANK_CYC : DIGIT_CYC) + 1);
  localparam logic [CW-1:0] BLAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] DLAST = CW'(DIGIT_CYC - 1);
  typedef enum logic {BLANK, SHOW} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d;
  logic [15:0] active_q, active_d, shadow_q, shadow_d;
  logic pending_q, pending_d, done_q, wrap;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= BLANK;
      cnt_q     <= '0;
      idx_q     <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      done_q    <= wrap;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    wrap    = en && state_q == SHOW && cnt_q == DLAST && idx_q == 2'd3;
    if (!en) begin
      state_d = BLANK;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (state_q == BLANK && cnt_q == BLAST) begin
      state_d = SHOW;
      cnt_d   = '0;
    end else if (state_q == SHOW && cnt_q == DLAST) begin
      state_d = BLANK;
      cnt_d   = '0;
      idx_d   = idx_q + 1'b1;
    end
    // a load coinciding with the wrap bypasses the shadow and goes live at once
    shadow_d  = load ? data_in : shadow_q;
    active_d  = !wrap ? active_q : load ? data_in : pending_q ? shadow_q : active_q;
    pending_d = !wrap && (load || pending_q);
  end
  assign char       = active_q[{idx_q, 2'b00} +: 4];
  assign an_blank   = state_q != SHOW;
  assign an         = state_q == SHOW ? ~(4'b0001 << idx_q) : 4'hf;
  assign pending    = pending_q;
  assign frame_done = done_q;
endmodule

// File: tb/tb_display_scanner.sv
// tb_display_scanner: frame-position reference model feeding a scoreboard, plus
// a table of directed spot checks and hand-written reset/enable sequences.
module tb_display_scanner;
  localparam int B = 2, D = 4, FR = 4 * (B + D);
  logic clk = 0, reset = 0, en = 0, load = 0;
  logic [15:0] data_in = '0;
  logic [3:0] char_o, an;
  logic an_blank, pending, frame_done;
  display_scanner #(.BLANK_CYC(B), .DIGIT_CYC(D)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .data_in(data_in),
    .char(char_o), .an_blank(an_blank), .an(an), .pending(pending),
    .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] an;
    logic       blank;
    logic [3:0] ch;
    logic       pend;
    logic       fd;
  } exp_t;
  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [3:0] ch;
    logic       pend;
    logic       fd;
  } vec_t;
  exp_t sb[$];
  vec_t tbl[29];
  int checks = 0, errors = 0, cyc = 0, pos = 0, hits = 0;
  logic [15:0] m_act = '0, m_sh = '0;
  logic m_pend = 0, m_fd = 0;
  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask
  function automatic exp_t model_out();
    exp_t e;
    int slot, off;
    logic [3:0] oh;
    slot = pos / (B + D);
    off  = pos % (B + D);
    oh   = 4'b0001 << slot;
    e.an    = off >= B ? ~oh : 4'hf;
    e.blank = off < B;
    e.ch    = m_act[4*slot +: 4];
    e.pend  = m_pend;
    e.fd    = m_fd;
    return e;
  endfunction
  task automatic step(logic e, logic l, logic [15:0] d);
    logic w;
    exp_t x;
    en = e; load = l; data_in = d;
    w = e && pos == FR - 1;
    pos = (!e || w) ? 0 : pos + 1;
    if (w) begin
      m_act  = l ? d : m_pend ? m_sh : m_act;
      m_pend = 0;
    end else if (l) begin
      m_sh   = d;
      m_pend = 1;
    end
    m_fd = w;
    sb.push_back(model_out());
    @(posedge clk);
    #1;
    cyc++;
    x = sb.pop_front();
    chk("an", an, x.an);
    chk("an_blank", an_blank, x.blank);
    chk("char", char_o, x.ch);
    chk("pending", pending, x.pend);
    chk("frame_done", frame_done, x.fd);
  endtask
  task automatic tbl_check();
    foreach (tbl[i]) if (tbl[i].cyc == cyc) begin
      hits++;
      chk("tbl_an", an, tbl[i].an);
      chk("tbl_char", char_o, tbl[i].ch);
      chk("tbl_pending", pending, tbl[i].pend);
      chk("tbl_frame_done", frame_done, tbl[i].fd);
    end
  endtask
  task automatic do_reset();
    #2 reset = 1;
    #1;
    chk("rst_an", an, 4'hf);
    chk("rst_an_blank", an_blank, 1'b1);
    chk("rst_char", char_o, 4'h0);
    chk("rst_pending", pending, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    pos = 0; m_act = '0; m_sh = '0; m_pend = 0; m_fd = 0; cyc = 0;
  endtask
  function automatic logic [15:0] ld_data(int c);
    return c == 3 ? 16'h3210 : c == 30 ? 16'hAAAA : c == 40 ? 16'h5555 :
           c == 71 ? 16'h9876 : 16'h1234;
  endfunction
  initial begin
    tbl = '{
      '{1, 4'hf, 4'h0, 0, 0},   '{2, 4'he, 4'h0, 0, 0},   '{3, 4'he, 4'h0, 0, 0},
      '{4, 4'he, 4'h0, 1, 0},   '{8, 4'hd, 4'h0, 1, 0},   '{23, 4'h7, 4'h0, 1, 0},
      '{24, 4'hf, 4'h0, 0, 1},  '{25, 4'hf, 4'h0, 0, 0},  '{26, 4'he, 4'h0, 0, 0},
      '{32, 4'hd, 4'h1, 1, 0},  '{38, 4'hb, 4'h2, 1, 0},  '{44, 4'h7, 4'h3, 1, 0},
      '{48, 4'hf, 4'h5, 0, 1},  '{50, 4'he, 4'h5, 0, 0},  '{71, 4'h7, 4'h5, 0, 0},
      '{72, 4'hf, 4'h6, 0, 1},  '{74, 4'he, 4'h6, 0, 0},  '{80, 4'hd, 4'h7, 0, 0},
      '{86, 4'hb, 4'h8, 0, 0},  '{92, 4'h7, 4'h9, 0, 0},  '{96, 4'hf, 4'h6, 0, 1},
      '{110, 4'hb, 4'h8, 0, 0}, '{112, 4'hf, 4'h6, 0, 0}, '{116, 4'hf, 4'h6, 1, 0},
      '{121, 4'hf, 4'h6, 1, 0}, '{122, 4'hf, 4'h6, 1, 0}, '{123, 4'he, 4'h6, 1, 0},
      '{144, 4'h7, 4'h9, 1, 0}, '{145, 4'hf, 4'h4, 0, 1}
    };
    en = 1;
    do_reset();
    for (int c = 0; c < 150; c++) begin
      step(!(c >= 111 && c <= 120), c inside {3, 30, 40, 71, 115}, ld_data(c));
      tbl_check();
    end
    chk("tbl_hits", hits, 29);
    step(1, 1, 16'hFFFF);
    for (int c = 0; c < 4; c++) step(1, 0, 16'h0);
    chk("pre_rst_pending", pending, 1'b1);
    chk("pre_rst_an", an, 4'hd);
    do_reset();
    chk("post_rst_an", an, 4'hf);
    for (int c = 0; c < 30; c++) begin
      step(1, 0, 16'h0);
      if (cyc == 2) begin
        chk("post_rst_show_an", an, 4'he);
        chk("post_rst_show_char", char_o, 4'h0);
      end
      if (cyc == 24) chk("post_rst_fd", frame_done, 1'b1);
      if (cyc == 26) chk("post_rst_char_after_wrap", char_o, 4'h0);
    end
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 Parameter BLANK_CYC, default 2, SHALL set the inter-digit blanking length in clock cycles (>=1).
REQ-002 Parameter DIGIT_CYC, default 4, SHALL set the per-digit display length in clock cycles (>=1).
REQ-003 clk  in  1  single system clock; all state changes SHALL occur on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 en  in  1  scan enable; 0 SHALL force blanking.
REQ-006 load  in  1  one-cycle strobe; captures data_in.
REQ-007 data_in  in  16  four 4-bit characters; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-008 char  out  4  character code for the current digit; drives the LED decoder char input.
REQ-009 an_blank  out  1  drives the LED decoder AN input; 0 = segments enabled, 1 = blank.
REQ-010 an  out  4  active-low digit anode select; an[i]=0 selects digit i.
REQ-011 pending  out  1  a loaded frame is waiting to be applied.
REQ-012 frame_done  out  1  one-cycle pulse at each completed 4-digit scan.

Function
REQ-013 The FSM SHALL have two states, BLANK and SHOW, a cycle counter, a 2-bit digit index, a 16-bit active register and a 16-bit shadow register.
REQ-014 In BLANK: an=4'b1111, an_blank=1, char=active[4*idx+:4].
REQ-015 In SHOW: an = all ones except bit idx = 0, an_blank=0, char=active[4*idx+:4].
REQ-016 In BLANK, the counter SHALL count 0..BLANK_CYC-1; at BLANK_CYC-1 the next state is SHOW with counter 0.
REQ-017 In SHOW, the counter SHALL count 0..DIGIT_CYC-1; at DIGIT_CYC-1 the next state is BLANK with counter 0 and idx+1 mod 4.
REQ-018 The wrap event is the edge that ends SHOW with idx=3; one frame is 4*(BLANK_CYC+DIGIT_CYC) cycles.
REQ-019 frame_done SHALL be 1 for exactly the cycle following each wrap event, otherwise 0.
REQ-020 load=1 (no wrap on the same edge) SHALL write shadow<=data_in and set pending=1; a later load before the wrap overwrites shadow.
REQ-021 On a wrap edge with pending=1 and load=0: active<=shadow, pending<=0.
REQ-022 On a wrap edge with load=1: active<=data_in directly, pending<=0.
REQ-023 The active register SHALL never change except on a wrap edge; no frame shows mixed old/new data.
REQ-024 en=0 SHALL force the next state to BLANK, counter 0, idx 0; no wrap occurs while en=0; load and pending behave normally.
REQ-025 When en returns to 1, scanning SHALL restart from BLANK, idx 0, counter 0.
REQ-026 All outputs SHALL be decoded from registered state only (no combinational path from inputs to outputs).

Reset
REQ-027 reset=1 SHALL immediately, without a clock edge, set state=BLANK, counter=0, idx=0, active=0, shadow=0, pending=0, frame_done=0, hence an=4'b1111, an_blank=1, char=4'h0.
REQ-028 reset asserted mid-frame SHALL discard any pending frame; scanning restarts from BLANK idx 0 on the first edge after release.

Verification (defaults BLANK_CYC=2, DIGIT_CYC=4)
REQ-029 Reset then en=1, no load -> cycles 0-1 an=1111, an_blank=1; cycles 2-5 an=1110, char=0; cycles 8-11 an=1101; frame_done high at cycle 24 only.
REQ-030 load with data_in=16'h3210 at cycle 3 -> pending=1 from cycle 4; active unchanged until wrap; frame_done cycle 24 with pending=0; next frame char=0,1,2,3 on an=1110,1101,1011,0111.
REQ-031 load 16'hAAAA then 16'h5555 within one frame -> next frame shows only 5 on all digits.
REQ-032 load 16'h9876 on exactly the wrap edge -> following frame shows 6,7,8,9; pending stays 0.
REQ-033 en=0 for 10 cycles mid-SHOW of idx 2 -> an=1111, an_blank=1 throughout, no frame_done; after en=1, two blank cycles then an=1110.
REQ-034 reset pulse during SHOW with pending=1 -> an=1111 and char=0 immediately, pending=0, no frame_done, display shows 0 on all digits afterward.
